his_bank_scheduler: RTL and testbench

Ping-pong controller for the per-pixel histogram RAM. Owns two histogram banks: one accumulates TDC hits while the other is drained by the downstream peak/data-processing stage over a valid/ready stream. Sequences the data/pixel/acquisition counters, swaps banks at frame end, clears each bin as it is read out, and drops hits when the drain falls behind.

---
 rtl/his_bank_scheduler.sv | 229 ++++++++++++++++++++++
 tb/tb_his_bank_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/his_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : his_bank_scheduler
// Purpose  : Ping-pong histogram bank controller. One bank accumulates hits
//            while the other is streamed out and cleared bin by bin.
// Revision : 1.0 - initial release
// ============================================================================
module his_bank_scheduler #(
    parameter int BIN_NUM_PER_HIS = 64,
    parameter int NB              = 6,
    parameter int PIXEL_NUM       = 200,
    parameter int DATA_NUM        = 2,
    parameter int ACQ_NUM         = 33333,
    parameter int PEAK_MAX        = 8
) (
    input  logic                clk,
    input  logic                res,
    input  logic                wr_en,
    input  logic [NB-1:0]       addr,
    output logic                wr_ready,
    output logic                acc_bank,
    output logic                frame_done,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [PEAK_MAX-1:0] rd_data,
    output logic [7:0]          rd_pixel,
    output logic [NB-1:0]       rd_bin,
    output logic                rd_last,
    output logic [15:0]         drop_cnt,
    output logic                init_busy
);

    localparam int BIN_NUM_PER_RAM = PIXEL_NUM * BIN_NUM_PER_HIS;
    localparam int IW = (BIN_NUM_PER_RAM > 1) ? $clog2(BIN_NUM_PER_RAM) : 1;
    localparam int DW = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;

    typedef enum logic [1:0] {
        ACQ_INIT      = 2'd0,
        ACQ_ACC       = 2'd1,
        ACQ_WAIT_SWAP = 2'd2
    } acq_state_t;

    typedef enum logic [1:0] {
        RD_EMPTY = 2'd0,
        RD_LOAD  = 2'd1,
        RD_VALID = 2'd2
    } rd_state_t;

    acq_state_t r_acq_state, w_acq_next;
    rd_state_t  r_rd_state, w_rd_next;

    logic [PEAK_MAX-1:0] r_mem [2][BIN_NUM_PER_RAM];

    logic [DW-1:0]       r_data_cnt;
    logic [7:0]          r_pixel_cnt;
    logic [19:0]         r_acq_cnt;
    logic [IW-1:0]       r_init_idx;
    logic [IW-1:0]       r_rd_idx;
    logic                r_acc_bank;
    logic                r_frame_done;
    logic [15:0]         r_drop_cnt;
    logic [PEAK_MAX-1:0] r_rd_data;
    logic [7:0]          r_rd_pixel;
    logic [NB-1:0]       r_rd_bin;

    logic                w_in_range;
    logic [IW-1:0]       w_hit_idx;
    logic [PEAK_MAX-1:0] w_hit_cur;
    logic [PEAK_MAX-1:0] w_hit_next;
    logic                w_hit_accept;
    logic                w_frame_end;
    logic                w_swap;
    logic                w_rd_bank;
    logic                w_rd_fire;
    logic                w_rd_at_last;

    // Out-of-range bins consume a counter slot but never touch the bank.
    assign w_in_range   = 32'(addr) < 32'(BIN_NUM_PER_HIS);
    assign w_hit_idx    = w_in_range ?
                          IW'(32'(r_pixel_cnt) * 32'(BIN_NUM_PER_HIS) + 32'(addr)) : '0;
    assign w_hit_cur    = r_mem[r_acc_bank][w_hit_idx];
    assign w_hit_next   = (&w_hit_cur) ? w_hit_cur : w_hit_cur + PEAK_MAX'(1);
    assign w_hit_accept = wr_en && (r_acq_state == ACQ_ACC);
    assign w_frame_end  = w_hit_accept
                       && (r_data_cnt  == DW'(DATA_NUM - 1))
                       && (r_pixel_cnt == 8'(PIXEL_NUM - 1))
                       && (r_acq_cnt   == 20'(ACQ_NUM - 1));
    assign w_rd_bank    = ~r_acc_bank;
    assign w_rd_fire    = (r_rd_state == RD_VALID) && rd_ready;
    assign w_rd_at_last = (r_rd_idx == IW'(BIN_NUM_PER_RAM - 1));

    assign wr_ready   = (r_acq_state == ACQ_ACC);
    assign init_busy  = (r_acq_state == ACQ_INIT);
    assign rd_valid   = (r_rd_state == RD_VALID);
    assign rd_last    = rd_valid && w_rd_at_last;
    assign acc_bank   = r_acc_bank;
    assign frame_done = r_frame_done;
    assign drop_cnt   = r_drop_cnt;
    assign rd_data    = r_rd_data;
    assign rd_pixel   = r_rd_pixel;
    assign rd_bin     = r_rd_bin;

    always_comb begin
        w_acq_next = r_acq_state;
        w_swap     = 1'b0;
        case (r_acq_state)
            ACQ_INIT: begin
                if (r_init_idx == IW'(BIN_NUM_PER_RAM - 1)) begin
                    w_acq_next = ACQ_ACC;
                end
            end
            ACQ_ACC: begin
                if (w_frame_end) begin
                    if (r_rd_state == RD_EMPTY) begin
                        w_swap = 1'b1;
                    end else begin
                        w_acq_next = ACQ_WAIT_SWAP;
                    end
                end
            end
            ACQ_WAIT_SWAP: begin
                if (r_rd_state == RD_EMPTY) begin
                    w_swap     = 1'b1;
                    w_acq_next = ACQ_ACC;
                end
            end
            default: w_acq_next = ACQ_INIT;
        endcase
    end

    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            RD_EMPTY: if (w_swap) w_rd_next = RD_LOAD;
            RD_LOAD:  w_rd_next = RD_VALID;
            RD_VALID: if (w_rd_fire && w_rd_at_last) w_rd_next = RD_EMPTY;
            default:  w_rd_next = RD_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_acq_state <= ACQ_INIT;
            r_rd_state  <= RD_EMPTY;
        end else begin
            r_acq_state <= w_acq_next;
            r_rd_state  <= w_rd_next;
        end
    end

    // Accumulating and readout banks are always distinct, so both writes can
    // land on the same edge without conflict.
    always_ff @(posedge clk) begin
        if (!res) begin
            if (r_acq_state == ACQ_INIT) begin
                r_mem[0][r_init_idx] <= '0;
                r_mem[1][r_init_idx] <= '0;
            end else if (w_hit_accept && w_in_range) begin
                r_mem[r_acc_bank][w_hit_idx] <= w_hit_next;
            end
            if (w_rd_fire) begin
                r_mem[w_rd_bank][r_rd_idx] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_data_cnt   <= '0;
            r_pixel_cnt  <= '0;
            r_acq_cnt    <= '0;
            r_init_idx   <= '0;
            r_rd_idx     <= '0;
            r_acc_bank   <= 1'b0;
            r_frame_done <= 1'b0;
            r_drop_cnt   <= '0;
            r_rd_data    <= '0;
            r_rd_pixel   <= '0;
            r_rd_bin     <= '0;
        end else begin
            r_frame_done <= w_swap;

            if (r_acq_state == ACQ_INIT) begin
                r_init_idx <= r_init_idx + IW'(1);
            end

            if (w_swap) begin
                r_acc_bank  <= ~r_acc_bank;
                r_data_cnt  <= '0;
                r_pixel_cnt <= '0;
                r_acq_cnt   <= '0;
                r_rd_idx    <= '0;
            end else if (w_hit_accept) begin
                if (r_data_cnt == DW'(DATA_NUM - 1)) begin
                    r_data_cnt <= '0;
                    if (r_pixel_cnt == 8'(PIXEL_NUM - 1)) begin
                        r_pixel_cnt <= '0;
                        r_acq_cnt   <= (r_acq_cnt == 20'(ACQ_NUM - 1)) ? '0 : r_acq_cnt + 20'd1;
                    end else begin
                        r_pixel_cnt <= r_pixel_cnt + 8'd1;
                    end
                end else begin
                    r_data_cnt <= r_data_cnt + DW'(1);
                end
            end

            if ((r_acq_state == ACQ_WAIT_SWAP) && wr_en && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end

            if (r_rd_state == RD_LOAD) begin
                r_rd_data  <= r_mem[w_rd_bank][0];
                r_rd_pixel <= '0;
                r_rd_bin   <= '0;
            end else if (w_rd_fire && !w_rd_at_last) begin
                r_rd_idx  <= r_rd_idx + IW'(1);
                r_rd_data <= r_mem[w_rd_bank][r_rd_idx + IW'(1)];
                if (r_rd_bin == NB'(BIN_NUM_PER_HIS - 1)) begin
                    r_rd_bin   <= '0;
                    r_rd_pixel <= r_rd_pixel + 8'd1;
                end else begin
                    r_rd_bin <= r_rd_bin + NB'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_his_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_his_bank_scheduler
// Purpose  : Directed bench for his_bank_scheduler (8-entry banks, plus a
//            2-bit-count instance sharing the same stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_his_bank_scheduler;

    logic       clk;
    logic       res;
    logic       wr_en;
    logic [2:0] addr;
    logic       rd_ready;

    logic       wr_ready, acc_bank, frame_done, rd_valid, rd_last, init_busy;
    logic [3:0] rd_data;
    logic [7:0] rd_pixel;
    logic [2:0] rd_bin;
    logic [15:0] drop_cnt;

    logic       s_wr_ready, s_acc_bank, s_frame_done, s_rd_valid, s_rd_last, s_init_busy;
    logic [1:0] s_rd_data;
    logic [7:0] s_rd_pixel;
    logic [2:0] s_rd_bin;
    logic [15:0] s_drop_cnt;

    int   total = 0;
    int   bad   = 0;
    logic exp_bank = 1'b0;

    typedef struct {
        logic [31:0] hits;
        logic [31:0] exp;
    } frame_t;
    frame_t tbl [6];

    his_bank_scheduler #(
        .BIN_NUM_PER_HIS(4), .NB(3), .PIXEL_NUM(2), .DATA_NUM(2), .ACQ_NUM(2), .PEAK_MAX(4)
    ) dut (
        .clk(clk), .res(res), .wr_en(wr_en), .addr(addr), .wr_ready(wr_ready),
        .acc_bank(acc_bank), .frame_done(frame_done), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_data(rd_data), .rd_pixel(rd_pixel), .rd_bin(rd_bin),
        .rd_last(rd_last), .drop_cnt(drop_cnt), .init_busy(init_busy)
    );

    his_bank_scheduler #(
        .BIN_NUM_PER_HIS(4), .NB(3), .PIXEL_NUM(2), .DATA_NUM(2), .ACQ_NUM(2), .PEAK_MAX(2)
    ) dut_sat (
        .clk(clk), .res(res), .wr_en(wr_en), .addr(addr), .wr_ready(s_wr_ready),
        .acc_bank(s_acc_bank), .frame_done(s_frame_done), .rd_valid(s_rd_valid),
        .rd_ready(rd_ready), .rd_data(s_rd_data), .rd_pixel(s_rd_pixel), .rd_bin(s_rd_bin),
        .rd_last(s_rd_last), .drop_cnt(s_drop_cnt), .init_busy(s_init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Nibble i of the result holds argument a<i>.
    function automatic logic [31:0] p8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7[3:0], a6[3:0], a5[3:0], a4[3:0], a3[3:0], a2[3:0], a1[3:0], a0[3:0]};
    endfunction

    task automatic do_reset(input int hold);
        res   = 1'b1;
        wr_en = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("rst_flags", 32'({wr_ready, acc_bank, frame_done, rd_valid, rd_last, init_busy}), 32'h01);
            chk("rst_data", 32'({rd_data, rd_pixel, rd_bin}), 32'h0);
            chk("rst_drop", 32'(drop_cnt), 32'h0);
            chk("rst_sat", 32'({s_wr_ready, s_acc_bank, s_frame_done, s_rd_valid, s_rd_last,
                                s_init_busy, s_rd_data, s_drop_cnt}), 32'h1_0000 << 2);
        end
        res = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("init_c%0d", i), 32'({init_busy, wr_ready, s_init_busy, s_wr_ready}), 32'b1010);
            @(negedge clk);
        end
        chk("init_exit", 32'({init_busy, wr_ready, s_init_busy, s_wr_ready}), 32'b0101);
        chk("init_bank", 32'({acc_bank, rd_valid}), 32'h0);
        exp_bank = 1'b0;
    endtask

    task automatic send_hits(input logic [31:0] h);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("hit%0d_wr_ready", i), 32'(wr_ready), 32'h1);
            wr_en = 1'b1;
            addr  = h[4*i +: 3];
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic check_swap();
        exp_bank = ~exp_bank;
        chk("swap_frame_done", 32'(frame_done), 32'h1);
        chk("swap_acc_bank", 32'(acc_bank), 32'(exp_bank));
        chk("swap_load_no_valid", 32'(rd_valid), 32'h0);
        @(negedge clk);
        chk("swap_pulse_end", 32'(frame_done), 32'h0);
        chk("swap_rd_valid", 32'(rd_valid), 32'h1);
    endtask

    task automatic drain(input logic [31:0] exp);
        logic [3:0] e;
        logic [1:0] es;
        rd_ready = 1'b1;
        for (int w = 0; w < 20 && rd_valid !== 1'b1; w++) @(negedge clk);
        chk("drain_start", 32'(rd_valid), 32'h1);
        if (rd_valid === 1'b1) begin
            for (int b = 0; b < 8; b++) begin
                e  = exp[4*b +: 4];
                es = (e > 4'd3) ? 2'd3 : e[1:0];
                chk($sformatf("beat%0d_data", b), 32'(rd_data), 32'(e));
                chk($sformatf("beat%0d_pos", b), 32'({rd_valid, rd_pixel, rd_bin, rd_last}),
                    32'({1'b1, 8'(b / 4), 3'(b % 4), b == 7}));
                chk($sformatf("beat%0d_sat", b),
                    32'({s_rd_valid, s_rd_pixel, s_rd_bin, s_rd_last, s_rd_data}),
                    32'({1'b1, 8'(b / 4), 3'(b % 4), b == 7, es}));
                @(negedge clk);
            end
            chk("drain_end_valid", 32'(rd_valid), 32'h0);
        end
    endtask

    initial begin
        tbl[0] = '{p8(1, 1, 1, 1, 1, 1, 1, 1), p8(0, 4, 0, 0, 0, 4, 0, 0)};
        tbl[1] = '{p8(0, 1, 2, 3, 0, 1, 2, 3), p8(2, 2, 0, 0, 0, 0, 2, 2)};
        tbl[2] = '{p8(5, 1, 1, 1, 1, 1, 1, 1), p8(0, 3, 0, 0, 0, 4, 0, 0)};
        tbl[3] = '{p8(2, 2, 2, 2, 2, 2, 2, 2), p8(0, 0, 4, 0, 0, 0, 4, 0)};
        tbl[4] = '{p8(0, 0, 0, 0, 0, 0, 0, 0), p8(4, 0, 0, 0, 4, 0, 0, 0)};
        tbl[5] = '{p8(7, 4, 6, 2, 1, 5, 3, 0), p8(0, 1, 0, 0, 1, 0, 1, 1)};

        res = 1'b1; wr_en = 1'b0; addr = '0; rd_ready = 1'b1;
        do_reset(3);

        // Table frames: accumulate, swap, full-rate drain.
        for (int f = 0; f < 6; f++) begin
            send_hits(tbl[f].hits);
            check_swap();
            drain(tbl[f].exp);
        end

        // Backpressure: held beat stays stable, overflow hits are dropped.
        rd_ready = 1'b0;
        send_hits(p8(0, 0, 0, 0, 0, 0, 0, 0));
        check_swap();
        chk("bp_first_beat", 32'({rd_data, rd_pixel, rd_bin, rd_last}), 32'({4'd4, 8'd0, 3'd0, 1'b0}));
        send_hits(tbl[1].hits);
        chk("bp_wr_ready_low", 32'(wr_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            addr  = 3'd1;
            @(negedge clk);
            chk("bp_hold", 32'({rd_valid, rd_data, rd_pixel, rd_bin, rd_last}),
                32'({1'b1, 4'd4, 8'd0, 3'd0, 1'b0}));
        end
        wr_en = 1'b0;
        chk("bp_drop_cnt", 32'(drop_cnt), 32'd3);
        drain(p8(4, 0, 0, 0, 4, 0, 0, 0));
        chk("bp_wait_swap", 32'({wr_ready, frame_done}), 32'h0);
        @(negedge clk);
        chk("bp_resume_ready", 32'(wr_ready), 32'h1);
        check_swap();
        drain(tbl[1].exp);
        chk("bp_drop_kept", 32'(drop_cnt), 32'd3);

        // Frame-end hit coincides with the final readout handshake.
        send_hits(tbl[0].hits);
        exp_bank = ~exp_bank;
        chk("sim_first_swap", 32'({frame_done, acc_bank}), 32'({1'b1, exp_bank}));
        fork
            send_hits(tbl[1].hits);
            drain(tbl[0].exp);
        join
        chk("sim_wr_ready_low", 32'({wr_ready, frame_done}), 32'h0);
        @(negedge clk);
        chk("sim_wr_ready_back", 32'(wr_ready), 32'h1);
        check_swap();
        drain(tbl[1].exp);

        // Reset in the middle of a drain, then a fresh frame.
        send_hits(tbl[0].hits);
        check_swap();
        for (int b = 0; b < 3; b++) begin
            chk($sformatf("mid_beat%0d", b), 32'(rd_data), (b == 1) ? 32'd4 : 32'd0);
            @(negedge clk);
        end
        chk("mid_beat3_bin", 32'({rd_valid, rd_bin}), 32'({1'b1, 3'd3}));
        do_reset(2);
        send_hits(tbl[3].hits);
        check_swap();
        drain(tbl[3].exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
